sample_ram_arb: RTL

Round-robin arbiter that shares the single pipelined Wishbone port of the sample RAM between two masters: master 0 is the USB sniffer capture writer and master 1 is the host debug/readout path. It sits between those masters and the RAM. It holds each grant until all of the owner's outstanding acks have returned, so acks always reach the right master. A per-grant beat limit keeps either master from starving the other.

---
 rtl/sample_ram_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sample_ram_arb.sv
// sample_ram_arb: round-robin arbiter sharing the sample RAM's single
// pipelined Wishbone port between the USB capture writer (m0) and the host
// debug/readout path (m1). A grant is held until every ack the owner is owed
// has come back, so acks can be routed purely by owner. A per-grant beat
// limit forces a release so neither master can starve the other.
module sample_ram_arb #(
    parameter int MAX_OUTSTANDING = 4,   // 1..15
    parameter int BURST_LEN       = 16   // 1..255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    output logic        m0_stall_o,
    output logic        m0_ack_o,
    output logic [31:0] m0_data_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    output logic        m1_stall_o,
    output logic        m1_ack_o,
    output logic [31:0] m1_data_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    input  logic        s_stall_i,
    input  logic        s_ack_i,
    input  logic [31:0] s_data_i
);

    localparam logic [3:0] MaxOut   = 4'(MAX_OUTSTANDING);
    localparam logic [7:0] BurstMax = 8'(BURST_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q;
    logic        owner_q;      // 0 = m0, 1 = m1
    logic        last_q;       // master granted most recently
    logic [3:0]  out_cnt_q;
    logic [3:0]  out_cnt_d;
    logic [7:0]  beat_cnt_q;
    logic [7:0]  beat_cnt_d;

    logic        in_grant;
    logic        owner_stb;
    logic        ack_valid;
    logic        gate;
    logic        accept;
    logic        release_grant;
    logic        winner;

    // Owner handshake qualification, counter next-state and release decision
    always_comb begin
        in_grant  = (state_q == GRANT);
        owner_stb = owner_q ? m1_stb_i : m0_stb_i;
        // Acks outside a grant, or with nothing outstanding, are protocol
        // noise and must neither reach a master nor move the counter.
        ack_valid = in_grant && s_ack_i && (out_cnt_q != 4'd0);
        // An ack returning this cycle frees its slot immediately, so a full
        // window reopens in the same cycle the first response lands.
        gate      = ((out_cnt_q < MaxOut) || ack_valid) && (beat_cnt_q < BurstMax);
        accept    = in_grant && owner_stb && gate && !s_stall_i;

        out_cnt_d = out_cnt_q;
        if (accept && !ack_valid) begin
            out_cnt_d = out_cnt_q + 4'd1;
        end else if (!accept && ack_valid) begin
            out_cnt_d = out_cnt_q - 4'd1;
        end

        beat_cnt_d = beat_cnt_q;
        if (accept && (beat_cnt_q < BurstMax)) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end

        release_grant = (out_cnt_d == 4'd0) && (!owner_stb || (beat_cnt_d == BurstMax));

        // On a tie the master that did not hold the previous grant wins.
        winner = (m0_stb_i && m1_stb_i) ? ~last_q : m1_stb_i;
    end

    // Slave request mux, per-master stall and ack routing
    always_comb begin
        s_stb_o  = in_grant && owner_stb && gate;
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        if (in_grant) begin
            if (owner_q) begin
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
            end else begin
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
            end
        end
        m0_stall_o = !(in_grant && !owner_q && gate && !s_stall_i);
        m1_stall_o = !(in_grant &&  owner_q && gate && !s_stall_i);
        m0_ack_o   = ack_valid && !owner_q;
        m1_ack_o   = ack_valid &&  owner_q;
    end

    // Read data fans out unqualified; the ack tells each master when it is theirs
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    // Arbitration FSM: grant on request in IDLE, release once drained
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            out_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_cnt_q <= '0;
                    if (m0_stb_i || m1_stb_i) begin
                        state_q    <= GRANT;
                        owner_q    <= winner;
                        last_q     <= winner;
                        beat_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    out_cnt_q  <= out_cnt_d;
                    beat_cnt_q <= beat_cnt_d;
                    if (release_grant) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
